// File: rtl/frame_stream_pkg.sv
// Shared types and raster-geometry helpers for the frame stream transmitter.
package frame_stream_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int unsigned total_len(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Sync window is [lo, hi): it starts right after the front porch.
  function automatic int unsigned sync_lo(input int unsigned act, input int unsigned fp);
    return act + fp;
  endfunction

  function automatic int unsigned sync_hi(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync);
    return act + fp + sync;
  endfunction

endpackage

// File: rtl/frame_stream_tx_video_timing_gen.sv
// Raster h/v counters with active/sync/last-pixel decode; counters sit at 0 while disabled.
module video_timing_gen
  import frame_stream_pkg::*;
#(
  parameter int H_ACTIVE = 170,
  parameter int V_ACTIVE = 240,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 8,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic act,
  output logic hs,
  output logic vs,
  output logic last_pixel
);

  localparam int unsigned H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SLO  = HW'(sync_lo(H_ACTIVE, H_FP));
  localparam logic [HW-1:0] H_SHI  = HW'(sync_hi(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SLO  = VW'(sync_lo(V_ACTIVE, V_FP));
  localparam logic [VW-1:0] V_SHI  = VW'(sync_hi(V_ACTIVE, V_FP, V_SYNC));
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign act        = en && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs         = en && (h_cnt >= H_SLO) && (h_cnt < H_SHI);
  assign vs         = en && (v_cnt >= V_SLO) && (v_cnt < V_SHI);
  assign last_pixel = en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/frame_stream_tx.sv
// Frame buffer to vsync/hsync/de RGB stream: stage 0 issues BRAM reads, stage 1 aligns timing with returned data.
module frame_stream_tx
  import frame_stream_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int H_ACTIVE   = 170,
  parameter int V_ACTIVE   = 240,
  parameter int H_FP       = 8,
  parameter int H_SYNC     = 16,
  parameter int H_BP       = 8,
  parameter int V_FP       = 2,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_continuous,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [3*WIDTH-1:0]    i_rd_data,
  output logic                  o_vsync,
  output logic                  o_hsync,
  output logic                  o_de,
  output logic [WIDTH-1:0]      o_r_data,
  output logic [WIDTH-1:0]      o_g_data,
  output logic [WIDTH-1:0]      o_b_data,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  act, hs, vs, last_pixel;
  logic                  de_q, hs_q, vs_q, last_q, done_q, busy_q;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .en         (state == RUN),
    .act        (act),
    .hs         (hs),
    .vs         (vs),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      de_q   <= act;
      hs_q   <= hs;
      vs_q   <= vs;
      last_q <= last_pixel;
      done_q <= last_q;
      // Busy spans the run plus the two pipeline cycles that drain the final pixel.
      busy_q <= (state == RUN) || last_q || ((state == IDLE) && i_start);
      case (state)
        IDLE: begin
          addr <= '0;
          if (i_start) state <= RUN;
        end
        RUN: begin
          if (last_pixel) begin
            addr <= '0;
            if (!i_continuous) state <= IDLE;
          end else if (act) begin
            addr <= addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rd_en      = act;
  assign o_rd_addr    = addr;
  assign o_de         = de_q;
  assign o_hsync      = hs_q;
  assign o_vsync      = vs_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_r_data     = de_q ? i_rd_data[3*WIDTH-1:2*WIDTH] : '0;
  assign o_g_data     = de_q ? i_rd_data[2*WIDTH-1:WIDTH]   : '0;
  assign o_b_data     = de_q ? i_rd_data[WIDTH-1:0]         : '0;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Randomised check of frame_stream_tx (small raster) against a position-based frame model.
module tb_frame_stream_tx;
  localparam int HA = 4, VA = 3, HFP = 1, HSW = 2, HBP = 1, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FL = HT * VT;
  localparam int W  = 8;
  localparam int AW = 8;

  logic          clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_continuous = 1'b0;
  logic          o_rd_en, o_vsync, o_hsync, o_de, o_busy, o_frame_done;
  logic [AW-1:0] o_rd_addr;
  logic [3*W-1:0] rd_data;
  logic [W-1:0]  o_r_data, o_g_data, o_b_data;

  frame_stream_tx #(
    .WIDTH(W), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_continuous(i_continuous),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(rd_data),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_r_data(o_r_data), .o_g_data(o_g_data), .o_b_data(o_b_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3*W-1:0] word(input int k);
    logic [W-1:0] a, b, c;
    a = W'(k); b = W'(k + 1); c = W'(k + 2);
    return {a, b, c};
  endfunction

  // Synchronous-read frame buffer, word k = {k, k+1, k+2}
  always @(posedge clk) if (o_rd_en) rd_data <= word(int'(o_rd_addr));

  int checks = 0, errors = 0, cyc = 0;
  // pos: frame position of the stage-0 cycle now (-1 = idle); p1/p2 one and two cycles back
  int pos = -1, p1 = -1, p2 = -1;
  logic       de_log [0:1023], hs_log [0:1023], vs_log [0:1023];
  logic       done_log [0:1023], busy_log [0:1023], rden_log [0:1023];
  logic [7:0] r_log [0:1023], addr_log [0:1023];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit act_of(input int p);
    return p >= 0 && (p % HT) < HA && (p / HT) < VA;
  endfunction
  function automatic bit hs_of(input int p);
    return p >= 0 && (p % HT) >= HA + HFP && (p % HT) < HA + HFP + HSW;
  endfunction
  function automatic bit vs_of(input int p);
    return p >= 0 && (p / HT) >= VA + VFP && (p / HT) < VA + VFP + VSW;
  endfunction
  function automatic int idx_of(input int p);
    return (p / HT) * HA + (p % HT);
  endfunction

  task automatic check_outputs();
    chk("rd_en", 64'(o_rd_en), 64'(act_of(pos)));
    if (act_of(pos)) chk("rd_addr", 64'(o_rd_addr), 64'(idx_of(pos)));
    chk("de", 64'(o_de), 64'(act_of(p1)));
    chk("hsync", 64'(o_hsync), 64'(hs_of(p1)));
    chk("vsync", 64'(o_vsync), 64'(vs_of(p1)));
    chk("rgb", 64'({o_r_data, o_g_data, o_b_data}), act_of(p1) ? 64'(word(idx_of(p1))) : 64'(0));
    chk("frame_done", 64'(o_frame_done), 64'(p2 == FL - 1));
    chk("busy", 64'(o_busy), 64'(pos >= 0 || p1 == FL - 1 || p2 == FL - 1));
    if (cyc < 1024) begin
      de_log[cyc] = o_de; hs_log[cyc] = o_hsync; vs_log[cyc] = o_vsync;
      done_log[cyc] = o_frame_done; busy_log[cyc] = o_busy; rden_log[cyc] = o_rd_en;
      r_log[cyc] = o_r_data; addr_log[cyc] = o_rd_addr;
    end
  endtask

  task automatic tick(input bit s, input bit c);
    @(negedge clk);
    check_outputs();
    i_start = s;
    i_continuous = c;
    if (rst) begin
      pos = -1; p1 = -1; p2 = -1;
    end else begin
      p2 = p1; p1 = pos;
      if (pos < 0)            pos = s ? 0 : -1;
      else if (pos == FL - 1) pos = c ? 0 : -1;
      else                    pos = pos + 1;
    end
    cyc++;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", 64'({o_rd_en, o_rd_addr, o_vsync, o_hsync, o_de, o_r_data, o_g_data,
                           o_b_data, o_busy, o_frame_done}), 64'(0));
    pos = -1; p1 = -1; p2 = -1;
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;
  endtask

  function automatic int count(input int which, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++)
      case (which)
        0: n += int'(de_log[i]);
        1: n += int'(vs_log[i]);
        default: n += int'(done_log[i]);
      endcase
    return n;
  endfunction

  initial begin
    int n;
    repeat (3) tick(0, 0);
    rst = 1'b0;
    repeat (2) tick(0, 0);

    // Single frame with hand-computed timing
    n = cyc;
    tick(1, 0);
    repeat (60) tick(0, 0);
    chk("lit_rden_n1", 64'(rden_log[n + 1]), 64'(1));
    chk("lit_addr_n1", 64'(addr_log[n + 1]), 64'(0));
    chk("lit_de_n1", 64'(de_log[n + 1]), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("lit_de_first_line", 64'(de_log[n + 2 + k]), 64'(1));
      chk("lit_r_first_line", 64'(r_log[n + 2 + k]), 64'(k));
    end
    chk("lit_de_n6", 64'(de_log[n + 6]), 64'(0));
    chk("lit_hs_n6", 64'(hs_log[n + 6]), 64'(0));
    chk("lit_hs_n7", 64'(hs_log[n + 7]), 64'(1));
    chk("lit_hs_n8", 64'(hs_log[n + 8]), 64'(1));
    chk("lit_hs_n9", 64'(hs_log[n + 9]), 64'(0));
    chk("lit_de_count", 64'(count(0, n, n + 60)), 64'(12));
    chk("lit_vs_count", 64'(count(1, n, n + 60)), 64'(8));
    chk("lit_done_count", 64'(count(2, n, n + 60)), 64'(1));
    chk("lit_done_n49", 64'(done_log[n + 49]), 64'(0));
    chk("lit_done_n50", 64'(done_log[n + 50]), 64'(1));
    chk("lit_busy_n50", 64'(busy_log[n + 50]), 64'(1));
    chk("lit_busy_n51", 64'(busy_log[n + 51]), 64'(0));

    // Continuous: frame 2 follows with no gap, then stops after continuous drops mid-frame 2
    n = cyc;
    tick(1, 1);
    repeat (60) tick(0, 1);
    repeat (90) tick(0, 0);
    chk("lit_cont_addr0", 64'(addr_log[n + 49]), 64'(0));
    chk("lit_cont_rden", 64'(rden_log[n + 49]), 64'(1));
    chk("lit_cont_de", 64'(de_log[n + 50]), 64'(1));
    chk("lit_cont_done", 64'(done_log[n + 50]), 64'(1));
    chk("lit_cont_frames", 64'(count(2, n, n + 150)), 64'(2));
    chk("lit_cont_de_count", 64'(count(0, n, n + 150)), 64'(24));
    chk("lit_cont_idle", 64'(busy_log[n + 99]), 64'(0));

    // Reset during line 1, then restart from address 0
    tick(1, 0);
    repeat (10) tick(0, 0);
    mid_reset();
    n = cyc;
    tick(1, 0);
    repeat (55) tick(0, 0);
    chk("lit_restart_addr", 64'(addr_log[n + 1]), 64'(0));
    chk("lit_restart_de", 64'(count(0, n, n + 55)), 64'(12));

    // Random start pulses (often mid-frame) and continuous toggling
    for (int i = 0; i < 1200; i++) begin
      if (i == 613) mid_reset();
      tick($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (110) tick(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
